// File: rtl/regfile_write_port_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_port_if
//  Description : Bundle between the writeback stage and the register-file
//                write port. The master drives the write request, address
//                and data. The slave returns the bit-major register image,
//                the decoded write enables and the commit status.
//                  RegWrite       master->slave  write request this cycle
//                  WriteRegister  master->slave  destination register index
//                  WriteData      master->slave  data to store
//                  reg_bits       slave->master  reg_bits[b][r] = bit b of reg r
//                  wr_onehot      slave->master  combinational write enables
//                  wr_ack         slave->master  write committed on last edge
//                  last_wr_addr   slave->master  index of last committed write
//  Revision    : 1.0  initial release
// ============================================================================
interface regfile_write_port_if #(
    parameter int WIDTH = 64,
    parameter int NREG  = 32
);
    localparam int c_AW = $clog2(NREG);

    logic                       RegWrite;
    logic [c_AW-1:0]            WriteRegister;
    logic [WIDTH-1:0]           WriteData;
    logic [WIDTH-1:0][NREG-1:0] reg_bits;
    logic [NREG-1:0]            wr_onehot;
    logic                       wr_ack;
    logic [c_AW-1:0]            last_wr_addr;

    modport master (
        output RegWrite, WriteRegister, WriteData,
        input  reg_bits, wr_onehot, wr_ack, last_wr_addr
    );

    modport slave (
        input  RegWrite, WriteRegister, WriteData,
        output reg_bits, wr_onehot, wr_ack, last_wr_addr
    );
endinterface
`default_nettype wire

// File: rtl/regfile_write_port.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_port
//  Description : Write side of the 32 x 64-bit register file. The module
//                decodes the destination address into one-hot enables and
//                holds the architectural registers in enable flip-flops. It
//                presents their contents as a bit-major bus for the read-mux
//                array. The register at ZERO_REG reads as zero and ignores
//                writes. A registered ack marks each committed write.
//  Ports       : clk    rising-edge clock
//                reset  synchronous active-high reset
//                bus    regfile_write_port_if.slave (request in, image and
//                       commit status out)
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_write_port #(
    parameter int WIDTH    = 64,
    parameter int NREG     = 32,
    parameter int ZERO_REG = 31
) (
    input  wire logic              clk,
    input  wire logic              reset,
    regfile_write_port_if.slave    bus
);
    localparam int              c_AW        = $clog2(NREG);
    localparam int              c_NGRP      = NREG / 8;
    localparam logic [c_AW-1:0] c_ZERO_ADDR = c_AW'(ZERO_REG);
    localparam logic [c_AW-1:0] c_LAST_RST  = c_AW'(31);

    wire  [c_NGRP-1:0]          w_grp_en;
    wire  [NREG-1:0]            w_onehot;
    wire  [WIDTH-1:0]           w_col [NREG];
    logic [WIDTH-1:0][NREG-1:0] w_reg_bits;
    wire                        w_commit;

    logic                       r_wr_ack;
    logic [c_AW-1:0]            r_last_wr_addr;

    // First decode level: the upper address bits pick one group of eight.
    // RegWrite is folded in here, so every downstream enable is already
    // qualified and X on the address cannot leak through when it is low.
    genvar g, i, r, b;
    generate
        for (g = 0; g < c_NGRP; g++) begin : g_predec
            assign w_grp_en[g] = bus.RegWrite &
                                 (bus.WriteRegister[c_AW-1:3] == (c_AW-3)'(g));
        end

        // Second decode level: a 3:8 decoder inside each group.
        for (g = 0; g < c_NGRP; g++) begin : g_grp
            for (i = 0; i < 8; i++) begin : g_dec
                if ((g * 8 + i) == ZERO_REG) begin : g_tie
                    assign w_onehot[g*8+i] = 1'b0;
                end else begin : g_en
                    assign w_onehot[g*8+i] = w_grp_en[g] &
                                             (bus.WriteRegister[2:0] == 3'(i));
                end
            end
        end

        // Storage: a hold/load mux in front of a plain flop per register.
        for (r = 0; r < NREG; r++) begin : g_reg
            if (r == ZERO_REG) begin : g_zero
                assign w_col[r] = '0;
            end else begin : g_store
                logic [WIDTH-1:0] r_q;
                wire  [WIDTH-1:0] w_d = w_onehot[r] ? bus.WriteData : r_q;

                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_q <= '0;
                    end else begin
                        r_q <= w_d;
                    end
                end

                assign w_col[r] = r_q;
            end
        end
    endgenerate

    // Transpose the register-major storage into the bit-major image that
    // the read-mux slices consume.
    always_comb begin
        w_reg_bits = '0;
        for (int rr = 0; rr < NREG; rr++) begin
            for (int bb = 0; bb < WIDTH; bb++) begin
                w_reg_bits[bb][rr] = w_col[rr][bb];
            end
        end
    end

    assign w_commit = bus.RegWrite & (bus.WriteRegister != c_ZERO_ADDR);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ack       <= 1'b0;
            r_last_wr_addr <= c_LAST_RST;
        end else begin
            r_wr_ack <= w_commit;
            if (w_commit) begin
                r_last_wr_addr <= bus.WriteRegister;
            end
        end
    end

    assign bus.reg_bits     = w_reg_bits;
    assign bus.wr_onehot    = w_onehot;
    assign bus.wr_ack       = r_wr_ack;
    assign bus.last_wr_addr = r_last_wr_addr;
endmodule
`default_nettype wire

// File: tb/tb_regfile_write_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_write_port
//  Description : Directed self-checking bench for regfile_write_port.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_write_port;
    localparam int c_WIDTH = 64;
    localparam int c_NREG  = 32;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    logic [c_WIDTH-1:0] exp_mem [c_NREG];

    regfile_write_port_if #(.WIDTH(c_WIDTH), .NREG(c_NREG)) rf_if ();

    regfile_write_port #(
        .WIDTH    (c_WIDTH),
        .NREG     (c_NREG),
        .ZERO_REG (31)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (rf_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] get_reg(input int r);
        logic [63:0] v;
        for (int bb = 0; bb < c_WIDTH; bb++) v[bb] = rf_if.reg_bits[bb][r];
        return v;
    endfunction

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] addr, input logic [63:0] data);
        rf_if.RegWrite      = we;
        rf_if.WriteRegister = addr;
        rf_if.WriteData     = data;
        #1;
    endtask

    task automatic check_image(input string tag);
        for (int r = 0; r < c_NREG; r++) begin
            check($sformatf("%s_x%0d", tag, r), get_reg(r), exp_mem[r]);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int r = 0; r < c_NREG; r++) exp_mem[r] = '0;

        // Reset with a pending write that must be discarded.
        reset = 1'b1;
        drive(1'b1, 5'd9, 64'h1234);
        step();
        step();
        check_image("rst");
        check("rst_ack", 64'(rf_if.wr_ack), 64'd0);
        check("rst_last", 64'(rf_if.last_wr_addr), 64'd31);

        // Single write to X5.
        reset = 1'b0;
        drive(1'b1, 5'd5, 64'h0123_4567_89AB_CDEF);
        check("oh_x5", 64'(rf_if.wr_onehot), 64'h0000_0020);
        step();
        exp_mem[5] = 64'h0123_4567_89AB_CDEF;
        check_image("w5");
        check("w5_ack", 64'(rf_if.wr_ack), 64'd1);
        check("w5_last", 64'(rf_if.last_wr_addr), 64'd5);

        // Write to the zero register is ignored.
        drive(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
        check("oh_x31", 64'(rf_if.wr_onehot), 64'd0);
        step();
        check_image("w31");
        check("w31_ack", 64'(rf_if.wr_ack), 64'd0);
        check("w31_last", 64'(rf_if.last_wr_addr), 64'd5);

        // Sweep every writable register on consecutive cycles.
        for (int r = 0; r < 31; r++) begin
            drive(1'b1, 5'(r), 64'(r) * 64'h1111);
            check($sformatf("oh_sweep%0d", r), 64'(rf_if.wr_onehot), 64'd1 << r);
            step();
            exp_mem[r] = 64'(r) * 64'h1111;
            check($sformatf("ack_sweep%0d", r), 64'(rf_if.wr_ack), 64'd1);
            check($sformatf("last_sweep%0d", r), 64'(rf_if.last_wr_addr), 64'(r));
        end
        drive(1'b0, 5'd0, 64'd0);
        step();
        check_image("sweep");
        check("sweep_ack_off", 64'(rf_if.wr_ack), 64'd0);
        check("sweep_last", 64'(rf_if.last_wr_addr), 64'd30);

        // Read during write returns the old value until the edge.
        drive(1'b1, 5'd7, 64'hAA);
        step();
        drive(1'b1, 5'd7, 64'h55);
        check("rdw_before", get_reg(7), 64'hAA);
        step();
        check("rdw_after", get_reg(7), 64'h55);
        exp_mem[7] = 64'h55;

        // Back-to-back writes to the same register: last one wins.
        drive(1'b1, 5'd9, 64'h1);
        step();
        check("b2b_ack1", 64'(rf_if.wr_ack), 64'd1);
        drive(1'b1, 5'd9, 64'h2);
        step();
        check("b2b_ack2", 64'(rf_if.wr_ack), 64'd1);
        check("b2b_val", get_reg(9), 64'h2);
        exp_mem[9] = 64'h2;

        // Idle with random address/data: nothing may change.
        for (int k = 0; k < 50; k++) begin
            drive(1'b0, 5'($urandom_range(0, 31)), {$urandom, $urandom});
            check($sformatf("idle_oh%0d", k), 64'(rf_if.wr_onehot), 64'd0);
            step();
            check_image($sformatf("idle%0d", k));
        end
        check("idle_ack", 64'(rf_if.wr_ack), 64'd0);
        check("idle_last", 64'(rf_if.last_wr_addr), 64'd9);

        // Reset dominates a same-cycle write.
        check("pre_rst_x3", get_reg(3), 64'h3333);
        reset = 1'b1;
        drive(1'b1, 5'd3, 64'hDEAD);
        step();
        for (int r = 0; r < c_NREG; r++) exp_mem[r] = '0;
        check("rstw_x3", get_reg(3), 64'd0);
        check("rstw_ack", 64'(rf_if.wr_ack), 64'd0);
        check("rstw_last", 64'(rf_if.last_wr_addr), 64'd31);
        reset = 1'b0;
        drive(1'b0, 5'd0, 64'd0);
        step();
        check_image("post_rst");
        check("post_rst_ack", 64'(rf_if.wr_ack), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/regfile_write_port.md
# regfile_write_port

Write side of the 32 x 64-bit register file: decodes a 5-bit destination address into 32 one-hot enables, holds the 32 architectural registers in enable flip-flops, and presents their contents as a bit-major bus. That bus feeds the existing 64-slice 32:1 read-mux array directly. Register 31 (XZR) is hardwired to zero. A registered acknowledge tells the writeback stage when each write has committed.

## Interface
Parameters:
- WIDTH, 64, bits per register
- NREG, 32, number of registers; the address width is log2(NREG) = 5
- ZERO_REG, 31, index that always reads 0 and ignores writes

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous reset, active-high; sampled only on the rising edge of clk
- RegWrite  in  1  write request for this cycle
- WriteRegister  in  5  destination register index
- WriteData  in  WIDTH  data to store
- reg_bits  out  [WIDTH-1:0][NREG-1:0]  bit-major register image; reg_bits[b][r] = bit b of register r; plugs straight into the read-mux array input
- wr_onehot  out  NREG  combinational decoded write enable for the current cycle
- wr_ack  out  1  registered one-cycle pulse: a write committed on the previous edge
- last_wr_addr  out  5  registered index of the most recently committed write

## Operation
- Decoder:
  - Structural, two levels: a 2:4 predecode of WriteRegister[4:3], gated by RegWrite, produces four group enables.
  - Each group enable drives a 3:8 decoder on WriteRegister[2:0].
  - wr_onehot[r] = RegWrite & (WriteRegister == r) & (r != ZERO_REG).
  - At most one bit of wr_onehot is high in any cycle.
- Storage:
  - Each register r != ZERO_REG is WIDTH enable-DFFs, built as a 2:1 mux (hold/load) in front of a plain DFF.
  - Selected by wr_onehot[r]; loads WriteData at the edge, otherwise holds.
- Zero register: no storage; reg_bits[b][ZERO_REG] is tied to 0 for all b.
- Commit tracking:
  - wr_ack <= RegWrite & (WriteRegister != ZERO_REG).
  - When that term is 1, last_wr_addr <= WriteRegister; otherwise it holds.
- No internal bypass:
  - A read of register r in the same cycle a write to r is presented returns the old value.
  - Forwarding is the pipeline's responsibility.
- Reset: synchronous, dominant over RegWrite in the same cycle.

## Timing
- Write latency: data presented in cycle N appears on reg_bits immediately after the rising edge ending cycle N.
- wr_ack is high throughout cycle N+1 for a write accepted in cycle N.
- wr_onehot is combinational from RegWrite/WriteRegister; it carries no state.
- Reset values, all held while reset is asserted:
  - every storage register = 0, so reg_bits is all zero
  - wr_ack = 0
  - last_wr_addr = 5'd31
- Reset asserted in the same cycle as RegWrite=1: the write is discarded and wr_ack stays 0 next cycle.
- Write to ZERO_REG:
  - no state changes
  - wr_onehot is all zero
  - wr_ack = 0 next cycle
  - last_wr_addr unchanged
- Back-to-back writes to the same register: the last one wins; each produces its own wr_ack pulse, so wr_ack can stay high for consecutive cycles.
- Back-to-back writes to different registers: both commit; wr_ack is high for two consecutive cycles.
- RegWrite=0: wr_onehot is all zero and all registers hold, regardless of WriteRegister and WriteData (including X on those inputs).

## Test plan
- Reset, then write 0x0123_4567_89AB_CDEF to X5 -> one cycle later:
  - bits of register 5 in reg_bits match the value
  - all other registers read 0
  - wr_ack=1, last_wr_addr=5
- Write 0xFFFF_FFFF_FFFF_FFFF to X31 -> no register changes, reg_bits[*][31]=0, wr_ack=0, last_wr_addr unchanged.
- Sweep: write value r*0x1111 to each register r=0..30 on consecutive cycles -> final image matches every entry; wr_ack high for 31 consecutive cycles; last_wr_addr=30.
- Same-cycle read-during-write: X7 holds 0xAA; present a write of 0x55 to X7 and sample reg_bits before the edge -> 0xAA; after the edge -> 0x55.
- Assert reset together with RegWrite=1, WriteRegister=3, WriteData=0xDEAD -> X3 = 0, wr_ack = 0, last_wr_addr = 31 next cycle.
- RegWrite=0 with WriteRegister and WriteData toggling randomly for 50 cycles -> wr_onehot always 0 and reg_bits unchanged throughout.
